// File: rtl/pixel_port_arbiter.sv
// Purpose : shares the VGA pixel write port between screen clear, snake draw and food draw.
// Latency : 1 cycle from ack (grant) to x_out/y_out/colour_out/plot.
// Backpr. : req/ack handshake; a requester holds req and data until ack, at most one ack per cycle.
//
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   clr_req/clr_last/clr_x/clr_y   clear requester (black fill), clr_last ends the burst
//   clr_ack                        combinational accept pulse for clear
//   snk_req/snk_x/snk_y/snk_colour snake requester, snk_ack accept pulse
//   fd_req/fd_x/fd_y/fd_colour     food requester, fd_ack accept pulse
//   x_out/y_out/colour_out/plot    registered pixel write to the VGA adapter
//   clr_busy                       clear burst currently owns the port
//   pix_count                      pixels issued since reset (wraps)
//   clip_err                       sticky out-of-range flag (only with ARB_CLIP_EN)
//
// Optional feature: define ARB_CLIP_EN to drop (but still ack) pixels outside
// X_MAX/Y_MAX and add the clip_err output.
module pixel_port_arbiter #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clr_req,
  input  logic           clr_last,
  input  logic [X_W-1:0] clr_x,
  input  logic [Y_W-1:0] clr_y,
  output logic           clr_ack,
  input  logic           snk_req,
  input  logic [X_W-1:0] snk_x,
  input  logic [Y_W-1:0] snk_y,
  input  logic [C_W-1:0] snk_colour,
  output logic           snk_ack,
  input  logic           fd_req,
  input  logic [X_W-1:0] fd_x,
  input  logic [Y_W-1:0] fd_y,
  input  logic [C_W-1:0] fd_colour,
  output logic           fd_ack,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] colour_out,
  output logic           plot,
  output logic           clr_busy,
`ifdef ARB_CLIP_EN
  output logic           clip_err,
`endif
  output logic [15:0]    pix_count
);

  localparam logic [0:0] NORMAL   = 1'b0;
  localparam logic [0:0] LOCK_CLR = 1'b1;
  localparam logic       PTR_SNK  = 1'b0;
  localparam logic       PTR_FD   = 1'b1;

  logic [0:0]     state;
  logic           rr_ptr;
  logic           gnt_clr, gnt_snk, gnt_fd, gnt_any;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [C_W-1:0] sel_colour;
  logic           do_plot;

  // Grants are suppressed while reset_n is low so no requester sees an ack
  // for a pixel that the reset is about to discard.
  always_comb begin
    gnt_clr = 1'b0;
    gnt_snk = 1'b0;
    gnt_fd  = 1'b0;
    if (reset_n) begin
      if (clr_req) begin
        gnt_clr = 1'b1;
      end else if (state == NORMAL) begin
        if (snk_req && fd_req) begin
          if (rr_ptr == PTR_SNK) gnt_snk = 1'b1;
          else                   gnt_fd  = 1'b1;
        end else if (snk_req) begin
          gnt_snk = 1'b1;
        end else if (fd_req) begin
          gnt_fd = 1'b1;
        end
      end
    end
  end

  assign gnt_any  = gnt_clr | gnt_snk | gnt_fd;
  assign clr_ack  = gnt_clr;
  assign snk_ack  = gnt_snk;
  assign fd_ack   = gnt_fd;
  assign clr_busy = (state == LOCK_CLR);

  always_comb begin
    sel_x      = clr_x;
    sel_y      = clr_y;
    sel_colour = '0;           // clear pixels are always black
    if (gnt_snk) begin
      sel_x      = snk_x;
      sel_y      = snk_y;
      sel_colour = snk_colour;
    end else if (gnt_fd) begin
      sel_x      = fd_x;
      sel_y      = fd_y;
      sel_colour = fd_colour;
    end
  end

`ifdef ARB_CLIP_EN
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);
  logic out_of_range;
  assign out_of_range = (sel_x > X_LIM) || (sel_y > Y_LIM);
  // Out-of-range pixels are acked so the requester never stalls, then dropped.
  assign do_plot = gnt_any && !out_of_range;

  always_ff @(posedge clk) begin
    if (!reset_n)                       clip_err <= 1'b0;
    else if (gnt_any && out_of_range)   clip_err <= 1'b1;
  end
`else
  assign do_plot = gnt_any;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      pix_count  <= '0;
      state      <= NORMAL;
      rr_ptr     <= PTR_SNK;
    end else begin
      plot <= do_plot;
      if (do_plot) begin
        x_out      <= sel_x;
        y_out      <= sel_y;
        colour_out <= sel_colour;
        pix_count  <= pix_count + 16'd1;
      end
      // The pointer always moves to the requester that was not just served.
      if (gnt_snk) rr_ptr <= PTR_FD;
      if (gnt_fd)  rr_ptr <= PTR_SNK;
      // A clear grant without clr_last locks the port; with it, the burst ends.
      if (gnt_clr) state <= clr_last ? NORMAL : LOCK_CLR;
    end
  end

endmodule

// File: doc/pixel_port_arbiter.md
Name: pixel_port_arbiter

Overview:
Shares the single VGA-adapter pixel write port between three requesters: screen clear (black fill), snake body/head draw, and food draw. Each requester uses a valid/ack handshake. The arbiter grants at most one pixel per cycle and registers it onto x_out/y_out/colour_out/plot. Clear gets burst ownership; snake and food alternate round-robin. It sits between snakeLogic/food/clear control and the VGA adapter, replacing the ad-hoc combinational draw mux.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
C_W, 3, colour width
X_MAX, 159, highest legal x (used only with ARB_CLIP_EN)
Y_MAX, 119, highest legal y (used only with ARB_CLIP_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
clr_req  in  1  clear requester has a pixel; x/y held stable until clr_ack
clr_last  in  1  qualifies the clr pixel as the final pixel of the clear burst
clr_x  in  X_W  clear pixel x
clr_y  in  Y_W  clear pixel y
clr_ack  out  1  one-cycle pulse: clear pixel accepted this cycle
snk_req  in  1  snake pixel request
snk_x  in  X_W  snake pixel x
snk_y  in  Y_W  snake pixel y
snk_colour  in  C_W  snake pixel colour
snk_ack  out  1  one-cycle pulse: snake pixel accepted
fd_req  in  1  food pixel request
fd_x  in  X_W  food pixel x
fd_y  in  Y_W  food pixel y
fd_colour  in  C_W  food pixel colour
fd_ack  out  1  one-cycle pulse: food pixel accepted
x_out  out  X_W  registered pixel x to VGA
y_out  out  Y_W  registered pixel y to VGA
colour_out  out  C_W  registered colour (0 for clear pixels)
plot  out  1  registered write enable to VGA
clr_busy  out  1  high while the clear burst owns the port
pix_count  out  16  pixels issued since reset; wraps at 16'hFFFF->0

Behaviour:
- Reset, synchronous when reset_n=0 at a clk edge: x_out=0, y_out=0, colour_out=0, plot=0, all acks=0, clr_busy=0, pix_count=0, state=NORMAL, rr_ptr=SNAKE. Reset mid-burst abandons the burst; the clear requester must restart.
- Handshake: a requester holds req and its data stable until ack. ack is combinational in the grant cycle. Data is sampled on that edge and appears on the outputs with plot=1 on the next cycle, i.e. a fixed 1-cycle latency. Deasserting req without ack is legal and has no effect.
- At most one ack per cycle. plot=0 in any cycle following a no-grant cycle; outputs hold their last values.
- State NORMAL:
  - clr_req has priority. It is granted and the state moves to LOCK_CLR unless clr_last is also set on that grant, in which case the state stays NORMAL.
  - Otherwise snake and food are arbitrated round-robin. With both requesting, grant the one rr_ptr names, then point rr_ptr at the other. With one requesting, grant it and point rr_ptr at the other.
- State LOCK_CLR: clr_busy=1. Only clear is granted; snk/fd requests wait with no ack. A clear grant with clr_last=1 returns to NORMAL on the next cycle. A cycle with clr_req=0 in LOCK_CLR grants nothing and stays locked.
- Clear pixels are always emitted with colour_out=0.
- pix_count increments by 1 on every grant, wraps modulo 2^16, and never saturates.

Optional Feature:
ARB_CLIP_EN:
- Defined: a pixel with x>X_MAX or y>Y_MAX is still acked (the requester never stalls) but is dropped: plot=0 next cycle, pix_count not incremented. A sticky output clip_err (1 bit, reset 0) is added and set on the first dropped pixel.
- Undefined: no bounds check and no clip_err port; every granted pixel is plotted.

Test Plan:
- Reset then idle 10 cycles -> plot=0, all acks 0, pix_count=0, clr_busy=0.
- snk_req=1 (x=10,y=20,col=3), others 0 -> snk_ack in cycle N; x_out=10, y_out=20, colour_out=3, plot=1 in cycle N+1; pix_count=1.
- snk_req and fd_req held high 6 cycles, both re-presenting after each ack -> acks alternate S,F,S,F,S,F; pix_count=6.
- Clear burst of 4 pixels (clr_last on the 4th) with snk_req high throughout -> clr_ack x4, clr_busy=1 from the first grant until after the 4th, no snk_ack until cycle 5, all 4 emitted with colour_out=0.
- clr_req single pixel with clr_last=1 -> state stays NORMAL, clr_busy never rises.
- reset_n pulsed low mid-clear-burst, then snk_req -> clr_busy=0 and the snake is granted in the first cycle after reset. With ARB_CLIP_EN, fd x=200 -> fd_ack=1, plot=0, clip_err=1.
